// File: rtl/jk_excite_driver.sv
// jk_excite_driver: turns a stream of desired Q values into J/K drive for an
// external jk_ff. Each target is queued, converted with the JK excitation
// table, applied for one edge, and the flip-flop's Q is then compared with
// the commanded value. Mismatches pulse 'mismatch' and bump a saturating count.
module jk_excite_driver #(
   parameter int DEPTH   = 4,
   parameter int CNT_W   = 8,
   parameter int DC_MODE = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tgt_valid,
   input  logic                     tgt_data,
   output logic                     tgt_ready,
   output logic                     J,
   output logic                     K,
   input  logic                     Q,
   output logic                     busy,
   output logic                     mismatch,
   output logic [CNT_W-1:0]         err_cnt,
   output logic [$clog2(DEPTH):0]   tgt_level
);

   localparam int               AW       = $clog2(DEPTH);
   localparam logic             DC       = (DC_MODE != 0);
   localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]      LVL_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {INIT, IDLE, DRIVE, CHECK} state_t;

   state_t      state_r, state_nx;
   logic        q_exp_r, q_exp_nx;
   logic        j_nx, k_nx;
   logic        check_s;
   logic        push_s, pop_s, head_s;
   logic [AW:0] wr_ptr_r, rd_ptr_r;
   logic        mem [DEPTH];

   // JK excitation table; the don't-care leg resolves to DC.
   function automatic logic [1:0] excite(input logic q, input logic t);
      case ({q, t})
         2'b00:   excite = {1'b0, DC};
         2'b01:   excite = {1'b1, DC};
         2'b10:   excite = {DC, 1'b1};
         2'b11:   excite = {DC, 1'b0};
         default: excite = {1'b0, 1'b1};
      endcase
   endfunction

   assign tgt_level = wr_ptr_r - rd_ptr_r;
   assign tgt_ready = (tgt_level != LVL_FULL);
   assign push_s    = tgt_valid && tgt_ready;
   assign pop_s     = (state_r == IDLE) && (tgt_level != LVL_ZERO);
   assign head_s    = mem[rd_ptr_r[AW-1:0]];
   assign busy      = (state_r != IDLE) || (tgt_level != LVL_ZERO);

   // FIFO storage: write the offered bit into the tail slot.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem[wr_ptr_r[AW-1:0]] <= tgt_data;
      end
   end

   // Next-state and next J/K: J/K are only non-zero for the single drive edge.
   always_comb begin
      state_nx = state_r;
      q_exp_nx = q_exp_r;
      j_nx     = 1'b0;
      k_nx     = 1'b0;
      check_s  = 1'b0;
      case (state_r)
         INIT: begin
            q_exp_nx = 1'b0;
            state_nx = CHECK;
         end
         IDLE: begin
            if (pop_s) begin
               {j_nx, k_nx} = excite(q_exp_r, head_s);
               q_exp_nx     = head_s;
               state_nx     = DRIVE;
            end else begin
               state_nx = IDLE;
            end
         end
         DRIVE: begin
            state_nx = CHECK;
         end
         CHECK: begin
            check_s  = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = INIT;
         end
      endcase
   end

   // State, J/K drive, check result, error count and FIFO pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= INIT;
         q_exp_r  <= 1'b0;
         J        <= 1'b0;
         K        <= 1'b1;
         mismatch <= 1'b0;
         err_cnt  <= {CNT_W{1'b0}};
         wr_ptr_r <= LVL_ZERO;
         rd_ptr_r <= LVL_ZERO;
      end else begin
         state_r  <= state_nx;
         q_exp_r  <= q_exp_nx;
         J        <= j_nx;
         K        <= k_nx;
         mismatch <= check_s && (Q != q_exp_r);
         if (check_s && (Q != q_exp_r) && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: two instances (DC_MODE 0 and 1) share the same
// stimulus, each drives its own behavioural jk_ff. A transaction-level model
// (queue of targets plus a cycle countdown) predicts every output each cycle.
module tb_jk_excite_driver;

   localparam int DEPTH = 4;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, tgt_valid, tgt_data, force_q0;
   logic [1:0]       tgt_ready, J, K, busy, mismatch, q_in;
   logic [CNT_W-1:0] err_cnt [2];
   logic [2:0]       tgt_level [2];
   bit   [1:0]       jk_q;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural jk_ff for each instance.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         case ({J[i], K[i]})
            2'b01:   jk_q[i] <= 1'b0;
            2'b10:   jk_q[i] <= 1'b1;
            2'b11:   jk_q[i] <= ~jk_q[i];
            default: jk_q[i] <= jk_q[i];
         endcase
      end
   end

   assign q_in[0] = force_q0 ? 1'b0 : jk_q[0];
   assign q_in[1] = force_q0 ? 1'b0 : jk_q[1];

   jk_excite_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DC_MODE(0)) u_dc0 (
      .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
      .tgt_ready(tgt_ready[0]), .J(J[0]), .K(K[0]), .Q(q_in[0]),
      .busy(busy[0]), .mismatch(mismatch[0]), .err_cnt(err_cnt[0]),
      .tgt_level(tgt_level[0]));

   jk_excite_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DC_MODE(1)) u_dc1 (
      .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data),
      .tgt_ready(tgt_ready[1]), .J(J[1]), .K(K[1]), .Q(q_in[1]),
      .busy(busy[1]), .mismatch(mismatch[1]), .err_cnt(err_cnt[1]),
      .tgt_level(tgt_level[1]));

   // ---------------- reference model ----------------
   // ph: 0 waiting for work, 1 J/K applied, 2 Q being verified, 3 post-reset start
   bit mq[$];
   int ph;
   bit cmd;
   bit ej[2], ek[2];
   bit emm;
   int eerr;

   bit       log_en;
   bit [1:0] jk_log0[$], jk_log1[$];
   int       max_level, pulses;
   bit       saw_not_ready;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
      end
   endtask

   function automatic bit [1:0] exc(input bit mode, input bit q, input bit t);
      if (q == t) return q ? {mode, 1'b0} : {1'b0, mode};
      else        return t ? {1'b1, mode} : {mode, 1'b1};
   endfunction

   function automatic void model_reset();
      mq.delete();
      ph = 3; cmd = 1'b0; emm = 1'b0; eerr = 0;
      for (int i = 0; i < 2; i++) begin ej[i] = 1'b0; ek[i] = 1'b1; end
   endfunction

   // Advance the model over the coming clock edge using current inputs.
   task automatic model_step();
      bit push, t;
      push = tgt_valid && (mq.size() < DEPTH);
      if (rst) begin
         model_reset();
         return;
      end
      emm = 1'b0;
      for (int i = 0; i < 2; i++) begin ej[i] = 1'b0; ek[i] = 1'b0; end
      case (ph)
         3: begin cmd = 1'b0; ph = 2; end
         0: if (mq.size() > 0) begin
               t = mq.pop_front();
               for (int i = 0; i < 2; i++) {ej[i], ek[i]} = exc(i[0], cmd, t);
               cmd = t;
               ph = 1;
            end
         1: ph = 2;
         default: begin
            if (!force_q0) begin
               chk("jkff_q_dc0", jk_q[0], cmd);
               chk("jkff_q_dc1", jk_q[1], cmd);
            end
            emm = ((force_q0 ? 1'b0 : cmd) != cmd);
            if (emm && eerr < 255) eerr++;
            ph = 0;
         end
      endcase
      if (push) mq.push_back(tgt_data);
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("J_%0d", i), J[i], ej[i]);
         chk($sformatf("K_%0d", i), K[i], ek[i]);
         chk($sformatf("mismatch_%0d", i), mismatch[i], emm);
         chk($sformatf("err_cnt_%0d", i), err_cnt[i], eerr);
         chk($sformatf("tgt_level_%0d", i), tgt_level[i], mq.size());
         chk($sformatf("tgt_ready_%0d", i), tgt_ready[i], mq.size() < DEPTH);
         chk($sformatf("busy_%0d", i), busy[i], (ph != 0) || (mq.size() > 0));
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
      if (log_en && ph == 1) begin
         jk_log0.push_back({J[0], K[0]});
         jk_log1.push_back({J[1], K[1]});
      end
      if (tgt_level[0] > max_level) max_level = tgt_level[0];
      if (!tgt_ready[0]) saw_not_ready = 1'b1;
      if (mismatch[0]) pulses++;
   endtask

   // Offer one bit and wait (bounded) until it is accepted; tgt_valid stays up.
   task automatic push_one(input bit b);
      bit acc;
      acc = 1'b0;
      tgt_valid = 1'b1;
      tgt_data  = b;
      for (int n = 0; n < 50 && !acc; n++) begin
         acc = (mq.size() < DEPTH);
         tick();
      end
      if (!acc) begin
         n_fail++;
         $display("FAIL push_timeout t=%0t got=stalled exp=accepted", $time);
      end
   endtask

   task automatic drain();
      tgt_valid = 1'b0;
      for (int n = 0; n < 200 && !(ph == 0 && mq.size() == 0); n++) tick();
      if (!(ph == 0 && mq.size() == 0)) begin
         n_fail++;
         $display("FAIL drain_timeout t=%0t got=busy exp=idle", $time);
      end
   endtask

   // ---------------- stimulus ----------------
   bit [1:0] exp0 [5];
   bit [1:0] exp1 [5];
   bit       tg   [5];

   initial begin
      tg   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      exp0 = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      exp1 = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b11};
      log_en = 1'b0; max_level = 0; pulses = 0; saw_not_ready = 1'b0;

      // 1: reset held two clocks, then INIT/CHECK, then IDLE
      rst = 1'b1; tgt_valid = 1'b0; tgt_data = 1'b0; force_q0 = 1'b0;
      model_reset();
      tick(); tick();
      chk("rst_J", J[0], 1'b0);
      chk("rst_K", K[0], 1'b1);
      chk("rst_err", err_cnt[0], 0);
      chk("rst_level", tgt_level[0], 0);
      chk("rst_ready", tgt_ready[0], 1'b1);
      rst = 1'b0;
      tick(); tick();
      chk("init_mismatch", mismatch[0], 1'b0);
      chk("init_err", err_cnt[1], 0);
      tick();
      chk("idle_J", J[0], 1'b0);
      chk("idle_K", K[0], 1'b0);
      chk("idle_busy", busy[0], 1'b0);

      // 2/3: excitation sequences for both don't-care modes
      log_en = 1'b1;
      for (int i = 0; i < 5; i++) push_one(tg[i]);
      drain();
      log_en = 1'b0;
      chk("seq_len0", jk_log0.size(), 5);
      chk("seq_len1", jk_log1.size(), 5);
      for (int i = 0; i < 5 && i < jk_log0.size() && i < jk_log1.size(); i++) begin
         chk($sformatf("seq_dc0_%0d", i), jk_log0[i], exp0[i]);
         chk($sformatf("seq_dc1_%0d", i), jk_log1[i], exp1[i]);
      end
      chk("seq_err", err_cnt[0], 0);
      chk("seq_q", jk_q[0], 1'b1);

      // 4: six back-to-back pushes fill the FIFO
      max_level = 0; saw_not_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_one(1'($urandom_range(1)));
      drain();
      chk("full_max_level", max_level, DEPTH);
      chk("full_ready_dropped", saw_not_ready, 1'b1);
      chk("full_level_end", tgt_level[0], 0);

      // 5: forced Q mismatch, then saturation
      force_q0 = 1'b1; pulses = 0;
      push_one(1'b1);
      drain();
      chk("mm_pulses", pulses, 1);
      chk("mm_err1", err_cnt[0], 1);
      for (int i = 0; i < 300; i++) push_one(1'b1);
      drain();
      chk("sat_err_dc0", err_cnt[0], 255);
      chk("sat_err_dc1", err_cnt[1], 255);
      force_q0 = 1'b0;

      // 6: reset during DRIVE with three targets queued
      for (int i = 0; i < 5; i++) push_one(1'($urandom_range(1)));
      tgt_valid = 1'b0;
      chk("pre_rst_level", tgt_level[0], 3);
      rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      chk("mid_rst_level", tgt_level[0], 0);
      chk("mid_rst_J", J[0], 1'b0);
      chk("mid_rst_K", K[1], 1'b1);
      chk("mid_rst_err", err_cnt[0], 0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      chk("post_rst_mismatch", mismatch[0], 1'b0);
      chk("post_rst_err", err_cnt[0], 0);

      // random traffic with occasional forced Q
      for (int n = 0; n < 600; n++) begin
         tgt_valid = 1'($urandom_range(1));
         tgt_data  = 1'($urandom_range(1));
         force_q0  = ($urandom_range(9) == 0);
         tick();
      end
      force_q0 = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
